// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated output-register mux.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED,
    MODE_RR
  } mode_e;

  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  // Index width for a channel count; never narrower than one bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: first set request at or after start, wrapping at CHANNELS-1.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IW       = chan_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       start,
  output logic [CHANNELS-1:0] gnt,
  output logic [IW-1:0]       gnt_idx,
  output logic                any
);

  localparam logic [IW:0] NumCh = (IW + 1)'(CHANNELS);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      // One extra bit keeps start+k exact before the wrap subtraction.
      sum = {1'b0, start} + (IW + 1)'(k);
      if (sum >= NumCh) begin
        sum = sum - NumCh;
      end
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated mux into a single output register with full-throughput valid/ready handshake.
module arb_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter mode_e       MODE     = MODE_RR,
  localparam int unsigned IW      = chan_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [IW-1:0]             out_chan,
  input  logic                      out_ready
);

  localparam logic [IW-1:0] LastCh = IW'(CHANNELS - 1);

  out_state_e          state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [IW-1:0]       chan_q, chan_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       start;
  logic [IW-1:0]       gnt_idx;
  logic [CHANNELS-1:0] gnt;
  logic                any;
  logic                load_en;
  logic                xfer;

  assign start = (MODE == MODE_RR) ? ptr_q : '0;

  rr_pick #(
    .CHANNELS(CHANNELS),
    .IW      (IW)
  ) u_pick (
    .req    (in_valid),
    .start  (start),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  assign load_en = (state_q == StEmpty) || out_ready;
  // Reset gates the handshake so nothing is accepted while the register is being cleared.
  assign xfer     = load_en && any && !reset;
  assign in_ready = xfer ? gnt : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull:  if (out_ready && !xfer) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (xfer) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (gnt[i]) begin
          data_d = in_data[i*WIDTH +: WIDTH];
        end
      end
      chan_d = gnt_idx;
      if (MODE == MODE_RR) begin
        ptr_d = (gnt_idx == LastCh) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter: WIDTH, 4, data bits per channel.
REQ-002 Parameter: CHANNELS, 4, number of input channels; legal range 2..16.
REQ-003 Parameter: MODE, MODE_RR, arbitration mode: MODE_RR (round-robin) or MODE_FIXED (lowest index wins).
REQ-004 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  CHANNELS  per-channel request.
REQ-008 in_data  input  CHANNELS x WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  CHANNELS  per-channel accept, at most one bit set.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  clog2(CHANNELS)  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load_en SHALL be (out_valid==0) OR (out_ready==1); load_en is combinational.
REQ-016 Input transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1.
REQ-017 in_ready SHALL be one-hot for the granted channel when load_en=1 and any in_valid is set; otherwise all zero.
REQ-018 in_ready MAY depend combinationally on in_valid and out_ready; out_valid/out_data/out_chan SHALL be registered only.
REQ-019 MODE_FIXED: grant SHALL go to the lowest-index asserted in_valid.
REQ-020 MODE_RR: grant SHALL go to the first asserted in_valid searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wrap-around).
REQ-021 MODE_RR: after a transfer from channel g, ptr SHALL become (g+1) mod CHANNELS; with no transfer ptr SHALL hold.
REQ-022 MODE_FIXED: ptr SHALL remain 0.
REQ-023 Latency: data transferred in cycle n SHALL appear on out_data with out_valid=1 in cycle n+1.
REQ-024 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on out_ready=1 with no transfer; FULL->FULL on out_ready=0 (hold out_data/out_chan unchanged) or on out_ready=1 with transfer (simultaneous drain and load, full throughput).
REQ-025 A channel whose in_valid drops before grant SHALL lose no state; arbitration is recomputed every cycle.
REQ-026 When all in_valid=0, in_ready SHALL be all zero and ptr SHALL hold.
REQ-027 out_data and out_chan SHALL hold last value when going EMPTY.

Reset
REQ-028 During reset: out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready all zero.
REQ-029 Reset asserted mid-transfer SHALL discard the output word immediately (asynchronously); first grant after release SHALL restart from channel 0.

Structure
REQ-030 Package mux_pkg SHALL hold the mode enum (MODE_FIXED, MODE_RR) and the channel index width function.
REQ-031 Sub-module rr_pick SHALL compute the combinational one-hot grant from request vector and start pointer; arb_mux instantiates it once.
REQ-032 Parameters SHALL be synthesisable for every legal CHANNELS, including non-powers of two (wrap at CHANNELS-1).

Verification
REQ-033 Reset then in_valid=4'b0100, in_data[2]=4'hA, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=4'hA, out_chan=2.
REQ-034 MODE_RR, all in_valid=1 held, out_ready=1, data[i]=i -> out_chan sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-035 MODE_FIXED, all in_valid=1, out_ready=1 -> out_chan=0 every cycle; channels 1..3 never get in_ready.
REQ-036 FULL with out_data=4'h5, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0, out_data stays 4'h5; on out_ready=1 next grant loads same cycle.
REQ-037 CHANNELS=3, MODE_RR, ptr at 2, in_valid=3'b011 -> grant channel 0 (wrap), next ptr=1.
REQ-038 Reset asserted while out_valid=1 -> out_valid=0 in that cycle without clk edge; after release with in_valid=4'b1010 grant channel 1.
